// File: rtl/rd_fram_buf_rdctl_if.sv
// DMA line-fill handshake plus buffer read port of the read-side frame buffer controller.
// The controller uses the master modport; the DMA/buffer side uses slave.
interface rd_fram_buf_rdctl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  line_req;
  logic                  line_bank;
  logic [10:0]           line_num;
  logic                  line_ack;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output line_req, line_bank, line_num, rd_addr,
    input  line_ack, rd_data
  );

  modport slave (
    input  line_req, line_bank, line_num, rd_addr,
    output line_ack, rd_data
  );
endinterface

// File: rtl/rd_fram_buf_rdctl.sv
// Ping-pong read controller: requests line fills from the DMA and reads pixels in step with DE.
// Optional macro RD_FRAM_BUF_RDCTL_UFCNT_EN adds a saturating underflowed-line counter.
module rd_fram_buf_rdctl #(
  parameter int H_ACT      = 1920,
  parameter int V_ACT      = 1080,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  vs_in,
  input  logic                  de_in,
  rd_fram_buf_rdctl_if.master   bus,
  output logic                  pix_de,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  vs_out,
  output logic                  underflow
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

  localparam logic [10:0] COL_LAST = 11'(H_ACT - 1);
  localparam logic [10:0] LINES    = 11'(V_ACT);

  state_t      state_q, state_d;
  logic [10:0] req_line_q, req_line_d;
  logic        discard_q, discard_d;

  logic        vs_q, de_q, pix_de_q;
  logic [1:0]  bank_ready_q, bank_ready_d;
  logic        bank_sel_q, bank_sel_d;
  logic [10:0] rd_line_q, rd_line_d;
  logic [11:0] addr_q, addr_d;
  logic        line_uf_q, line_uf_d;
  logic        underflow_q, underflow_d;

  logic frame_start, de_rise, de_fall, ack_take, line_in_range, rd_bank, uf_flag;

  assign frame_start   = vs_in & ~vs_q;
  assign de_rise       = de_in & ~de_q;
  assign de_fall       = ~de_in & de_q;
  assign ack_take      = (state_q == WAIT_ACK) & bus.line_ack & ~discard_q & ~frame_start;
  assign line_in_range = frame_start | (rd_line_q < LINES);
  // A frame start coinciding with DE rise restarts on bank 0 with nothing ready.
  assign rd_bank       = frame_start ? 1'b0 : bank_sel_q;
  assign uf_flag       = de_rise & line_in_range & (frame_start | ~bank_ready_q[bank_sel_q]);

  // Request FSM: state register
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= IDLE;
      req_line_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_line_q <= req_line_d;
      discard_q  <= discard_d;
    end
  end

  // Request FSM: next state
  always_comb begin
    state_d    = state_q;
    req_line_d = req_line_q;
    discard_d  = discard_q;
    if (frame_start) begin
      req_line_d = '0;
      // An in-flight fill belongs to the old frame; swallow its ack before restarting.
      if (state_q == WAIT_ACK && !bus.line_ack) begin
        state_d   = WAIT_ACK;
        discard_d = 1'b1;
      end else begin
        state_d   = REQ;
        discard_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        REQ: begin
          if (req_line_q == LINES)                state_d = IDLE;
          else if (!bank_ready_q[req_line_q[0]])  state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (bus.line_ack) begin
            state_d   = REQ;
            discard_d = 1'b0;
            if (!discard_q) req_line_d = req_line_q + 11'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Request FSM: outputs
  always_comb begin
    bus.line_req  = (state_q == WAIT_ACK) & ~discard_q;
    bus.line_bank = req_line_q[0];
    bus.line_num  = req_line_q;
  end

  // Read side: registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      pix_de_q     <= 1'b0;
      bank_ready_q <= 2'b00;
      bank_sel_q   <= 1'b0;
      rd_line_q    <= '0;
      addr_q       <= '0;
      line_uf_q    <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      vs_q         <= vs_in;
      de_q         <= de_in;
      pix_de_q     <= de_in;
      bank_ready_q <= bank_ready_d;
      bank_sel_q   <= bank_sel_d;
      rd_line_q    <= rd_line_d;
      addr_q       <= addr_d;
      line_uf_q    <= line_uf_d;
      underflow_q  <= underflow_d;
    end
  end

  // Read side: next state
  always_comb begin
    bank_ready_d = bank_ready_q;
    bank_sel_d   = bank_sel_q;
    rd_line_d    = rd_line_q;
    addr_d       = addr_q;
    line_uf_d    = line_uf_q;
    if (ack_take) bank_ready_d[req_line_q[0]] = 1'b1;
    if (de_fall && line_in_range) begin
      bank_ready_d[bank_sel_q] = 1'b0;
      bank_sel_d               = ~bank_sel_q;
      rd_line_d                = rd_line_q + 11'd1;
    end
    if (frame_start) begin
      bank_ready_d = 2'b00;
      bank_sel_d   = 1'b0;
      rd_line_d    = '0;
    end
    if (de_rise) begin
      addr_d    = {rd_bank, 11'd0};
      line_uf_d = frame_start | ~line_in_range | ~bank_ready_q[bank_sel_q];
    end else if (de_in && addr_q[10:0] != COL_LAST) begin
      // col stays below 2047 here, so the increment never carries into the bank bit
      addr_d = addr_q + 12'd1;
    end
    underflow_d = (underflow_q & ~frame_start) | uf_flag;
  end

  // The address is presented combinationally so the RAM's own output register
  // supplies the single cycle of de_in -> pix_data latency.
  assign bus.rd_addr = ADDR_WIDTH'(addr_d);
  assign pix_de      = pix_de_q;
  assign pix_data    = (pix_de_q && !line_uf_q) ? bus.rd_data : '0;
  assign vs_out      = vs_q;
  assign underflow   = underflow_q;

`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
  logic [15:0] uf_cnt_q;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)                              uf_cnt_q <= '0;
    else if (uf_flag && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
  end

  assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_rd_fram_buf_rdctl.sv
// Directed bench for rd_fram_buf_rdctl with H_ACT=8, V_ACT=4 and a synchronous-read RAM model.
module tb_rd_fram_buf_rdctl;
  logic clk, rst, vs_in, de_in, pix_de, vs_out, underflow;
  logic [31:0] pix_data;
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
  logic [15:0] ufcnt;
`endif
  int checks = 0;
  int errors = 0;

  logic [11:0] addr_obs [0:15];
  logic        pde_obs  [0:15];
  logic [31:0] pdat_obs [0:15];

  rd_fram_buf_rdctl_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  rd_fram_buf_rdctl #(.H_ACT(8), .V_ACT(4), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .rd_clk(clk), .rd_rst(rst), .vs_in(vs_in), .de_in(de_in), .bus(bus),
    .pix_de(pix_de), .pix_data(pix_data), .vs_out(vs_out), .underflow(underflow)
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
    , .underflow_cnt(ufcnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Buffer contents: word at address a holds {20'hC0DE0, a}; one-cycle read latency.
  always @(posedge clk) bus.rd_data <= {20'hC0DE0, bus.rd_addr};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ack_pulse(input int d);
    repeat (d) step();
    bus.line_ack = 1'b1;
    step();
    bus.line_ack = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.line_req) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic frame_pulse();
    vs_in = 1'b1;
    step();
    vs_in = 1'b0;
  endtask

  // Drives one DE burst of len cycles; slot i holds rd_addr during DE cycle i and
  // the pixel outputs produced by DE cycle i-1.
  task automatic drive_de(input int len);
    for (int i = 0; i <= len + 1; i++) begin
      de_in = (i < len);
      #1;
      addr_obs[i] = bus.rd_addr;
      pde_obs[i]  = pix_de;
      pdat_obs[i] = pix_data;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vs_in = 1'b0; de_in = 1'b0; bus.line_ack = 1'b0;
    repeat (3) step();
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL rst_line_req got %b want 0", bus.line_req); end
    checks++; if (bus.line_bank !== 1'b0 || bus.line_num !== 11'd0) begin errors++; $display("FAIL rst_line_id got %b/%0d want 0/0", bus.line_bank, bus.line_num); end
    checks++; if (bus.rd_addr !== 12'h000) begin errors++; $display("FAIL rst_rd_addr got %h want 000", bus.rd_addr); end
    checks++; if (pix_de !== 1'b0 || pix_data !== 32'h0) begin errors++; $display("FAIL rst_pix got %b/%h want 0/0", pix_de, pix_data); end
    checks++; if (vs_out !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got %b/%b want 0/0", vs_out, underflow); end
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
    checks++; if (ufcnt !== 16'd0) begin errors++; $display("FAIL rst_ufcnt got %0d want 0", ufcnt); end
`endif
    rst = 1'b0;
    repeat (3) step();
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b want 0", bus.line_req); end
  endtask

  task automatic test_fill_and_read();
    bit ok;
    vs_in = 1'b1;
    step();
    checks++; if (vs_out !== 1'b1) begin errors++; $display("FAIL vs_out_delay got %b want 1", vs_out); end
    vs_in = 1'b0;
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd0 || bus.line_bank !== 1'b0) begin errors++; $display("FAIL req_line0 got req=%b num=%0d bank=%b want 1/0/0", ok, bus.line_num, bus.line_bank); end
    ack_pulse(3);
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL req_gap got %b want 0", bus.line_req); end
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd1 || bus.line_bank !== 1'b1) begin errors++; $display("FAIL req_line1 got req=%b num=%0d bank=%b want 1/1/1", ok, bus.line_num, bus.line_bank); end
    ack_pulse(3);
    repeat (3) step();
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL no_overwrite got %b want 0", bus.line_req); end
    drive_de(8);
    for (int i = 0; i < 8; i++) begin
      checks++; if (addr_obs[i] !== {1'b0, 11'(i)}) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, addr_obs[i], {1'b0, 11'(i)}); end
    end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (pde_obs[i] !== 1'b1 || pdat_obs[i] !== {20'hC0DE0, 1'b0, 11'(i - 1)}) begin errors++; $display("FAIL fill_pix[%0d] got %b/%h want 1/%h", i, pde_obs[i], pdat_obs[i], {20'hC0DE0, 1'b0, 11'(i - 1)}); end
    end
    checks++; if (pde_obs[9] !== 1'b0 || pdat_obs[9] !== 32'h0) begin errors++; $display("FAIL fill_pix_end got %b/%h want 0/0", pde_obs[9], pdat_obs[9]); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL fill_underflow got %b want 0", underflow); end
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd2 || bus.line_bank !== 1'b0) begin errors++; $display("FAIL req_line2 got req=%b num=%0d bank=%b want 1/2/0", ok, bus.line_num, bus.line_bank); end
  endtask

  task automatic test_discard();
    frame_pulse();
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL discard_drop got %b want 0", bus.line_req); end
    repeat (2) step();
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL discard_hold got %b want 0", bus.line_req); end
    ack_pulse(0);
    checks++; if (bus.line_req !== 1'b0) begin errors++; $display("FAIL discard_gap got %b want 0", bus.line_req); end
    step();
    checks++; if (bus.line_req !== 1'b1 || bus.line_num !== 11'd0 || bus.line_bank !== 1'b0) begin errors++; $display("FAIL discard_rereq got req=%b num=%0d bank=%b want 1/0/0", bus.line_req, bus.line_num, bus.line_bank); end
  endtask

  task automatic test_underflow();
    bit ok;
    ack_pulse(3);
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd1 || bus.line_bank !== 1'b1) begin errors++; $display("FAIL uf_req1 got req=%b num=%0d bank=%b want 1/1/1", ok, bus.line_num, bus.line_bank); end
    drive_de(8);
    checks++; if (pdat_obs[1] !== 32'hC0DE0000 || pdat_obs[8] !== 32'hC0DE0007) begin errors++; $display("FAIL uf_line0_pix got %h,%h want C0DE0000,C0DE0007", pdat_obs[1], pdat_obs[8]); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before got %b want 0", underflow); end
    drive_de(8);
    checks++; if (addr_obs[0] !== 12'h800) begin errors++; $display("FAIL uf_addr got %h want 800", addr_obs[0]); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (pde_obs[i] !== 1'b1 || pdat_obs[i] !== 32'h0) begin errors++; $display("FAIL uf_pix[%0d] got %b/%h want 1/0", i, pde_obs[i], pdat_obs[i]); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b want 1", underflow); end
    checks++; if (bus.line_req !== 1'b1 || bus.line_num !== 11'd1) begin errors++; $display("FAIL uf_req_stable got %b/%0d want 1/1", bus.line_req, bus.line_num); end
    frame_pulse();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", underflow); end
  endtask

  task automatic test_de_saturate();
    bit ok;
    ack_pulse(1);
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd0) begin errors++; $display("FAIL sat_req0 got req=%b num=%0d want 1/0", ok, bus.line_num); end
    ack_pulse(3);
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd1) begin errors++; $display("FAIL sat_req1 got req=%b num=%0d want 1/1", ok, bus.line_num); end
    ack_pulse(3);
    repeat (2) step();
    drive_de(10);
    for (int i = 0; i < 10; i++) begin
      int c = (i < 7) ? i : 7;
      checks++; if (addr_obs[i] !== {1'b0, 11'(c)}) begin errors++; $display("FAIL sat_addr[%0d] got %h want %h", i, addr_obs[i], {1'b0, 11'(c)}); end
    end
    for (int i = 1; i <= 10; i++) begin
      int c = (i - 1 < 7) ? i - 1 : 7;
      checks++; if (pdat_obs[i] !== {20'hC0DE0, 1'b0, 11'(c)}) begin errors++; $display("FAIL sat_pix[%0d] got %h want %h", i, pdat_obs[i], {20'hC0DE0, 1'b0, 11'(c)}); end
    end
    checks++; if (pde_obs[11] !== 1'b0) begin errors++; $display("FAIL sat_pix_de_end got %b want 0", pde_obs[11]); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL sat_underflow got %b want 0", underflow); end
  endtask

  task automatic test_same_cycle();
    vs_in = 1'b1;
    drive_de(4);
    vs_in = 1'b0;
    checks++; if (addr_obs[0] !== 12'h000) begin errors++; $display("FAIL same_addr got %h want 000", addr_obs[0]); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (pdat_obs[i] !== 32'h0) begin errors++; $display("FAIL same_pix[%0d] got %h want 0", i, pdat_obs[i]); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL same_underflow got %b want 1", underflow); end
    drive_de(4);
    checks++; if (addr_obs[3] !== 12'h803 || pdat_obs[2] !== 32'h0) begin errors++; $display("FAIL next_line got %h/%h want 803/0", addr_obs[3], pdat_obs[2]); end
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
    checks++; if (ufcnt !== 16'd3) begin errors++; $display("FAIL ufcnt got %0d want 3", ufcnt); end
`endif
  endtask

  task automatic test_reset_midline();
    bit ok;
    ack_pulse(1);
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd0) begin errors++; $display("FAIL mid_req0 got req=%b num=%0d want 1/0", ok, bus.line_num); end
    de_in = 1'b1;
    repeat (3) step();
    checks++; if (underflow !== 1'b1 || bus.rd_addr !== 12'h003) begin errors++; $display("FAIL mid_pre got %b/%h want 1/003", underflow, bus.rd_addr); end
    rst = 1'b1;
    #1;
    checks++; if (bus.line_req !== 1'b0 || pix_de !== 1'b0 || bus.rd_addr !== 12'h000) begin errors++; $display("FAIL mid_rst got req=%b de=%b addr=%h want 0/0/000", bus.line_req, pix_de, bus.rd_addr); end
    checks++; if (pix_data !== 32'h0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %h/%b want 0/0", pix_data, underflow); end
`ifdef RD_FRAM_BUF_RDCTL_UFCNT_EN
    checks++; if (ufcnt !== 16'd0) begin errors++; $display("FAIL mid_rst_ufcnt got %0d want 0", ufcnt); end
`endif
    de_in = 1'b0;
    step();
    rst = 1'b0;
    ack_pulse(1);
    repeat (3) step();
    checks++; if (bus.line_req !== 1'b0 || bus.line_num !== 11'd0) begin errors++; $display("FAIL mid_ack_ignored got %b/%0d want 0/0", bus.line_req, bus.line_num); end
    frame_pulse();
    wait_req(ok);
    checks++; if (!ok || bus.line_num !== 11'd0 || bus.line_bank !== 1'b0) begin errors++; $display("FAIL mid_restart got req=%b num=%0d bank=%b want 1/0/0", ok, bus.line_num, bus.line_bank); end
  endtask

  initial begin
    test_reset();
    test_fill_and_read();
    test_discard();
    test_underflow();
    test_de_saturate();
    test_same_cycle();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
